vec_mul_seq: RTL and testbench

Folding sequencer for elementwise signed integer vector multiplication. It accepts a full `length`-element operand pair through a valid/ready handshake and time-multiplexes one internal `lanes`-wide `vec_mul_int` over `length/lanes` beats. It collects the products in an output buffer and presents the full product vector with a valid/ready handshake. It sits between the operand-staging logic and the downstream MX scaling/accumulation stage wherever a full-width multiplier array is too expensive.

---
 rtl/vec_mul_seq.sv | 202 ++++++++++++++++++++
 tb/tb_vec_mul_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_mul_seq.sv
// Folding sequencer: time-multiplexes a lanes-wide signed multiplier over length/lanes beats.
// Optional build macro VEC_MUL_SEQ_PIPE_EN inserts a register stage ahead of the product buffer.

module vec_mul_int #(
  parameter int bit_width = 8,
  parameter int lanes     = 8,
  parameter int prd_width = 2*bit_width
) (
  input  logic signed [bit_width-1:0] a [lanes],
  input  logic signed [bit_width-1:0] b [lanes],
  output logic signed [prd_width-1:0] p [lanes]
);
  localparam int full_w = 2*bit_width;

  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    logic signed [full_w-1:0] full;
    // Full-width product is exact; widening to prd_width sign-extends.
    assign full  = full_w'(a[gi]) * full_w'(b[gi]);
    assign p[gi] = prd_width'(full);
  end
endmodule

module vec_mul_seq #(
  parameter  int bit_width = 8,
  parameter  int length    = 32,
  parameter  int lanes     = 8,
  parameter  int prd_width = 2*bit_width,
  localparam int beats     = length/lanes,
  localparam int beat_w    = (beats > 1) ? $clog2(beats) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [bit_width-1:0] i_vec_a [length],
  input  logic signed [bit_width-1:0] i_vec_b [length],
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [prd_width-1:0] o_prd [length],
  output logic                        o_busy,
  output logic [beat_w-1:0]           o_beat
);

  if (length % lanes != 0) begin : g_len_chk
    $error("vec_mul_seq: length must be a multiple of lanes");
  end
  if (prd_width < 2*bit_width) begin : g_prd_chk
    $error("vec_mul_seq: prd_width must be at least 2*bit_width");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                      state_reg, state_next;
  logic [beat_w-1:0]           beat_reg, beat_next;
  logic                        accept;
  logic                        last_beat;
  logic signed [bit_width-1:0] a_reg [length];
  logic signed [bit_width-1:0] b_reg [length];
  logic signed [prd_width-1:0] prd_reg [length];
  logic signed [bit_width-1:0] mul_a [lanes];
  logic signed [bit_width-1:0] mul_b [lanes];
  logic signed [prd_width-1:0] mul_p [lanes];

  // Buffer write port; fed directly or through the optional pipe stage.
  logic                        wr_en;
  logic [beat_w-1:0]           wr_idx;
  logic signed [prd_width-1:0] wr_prd [lanes];

  assign last_beat = (beat_reg == beat_w'(beats-1));

  always_comb begin
    for (int j = 0; j < lanes; j++) begin
      mul_a[j] = a_reg[int'(beat_reg)*lanes + j];
      mul_b[j] = b_reg[int'(beat_reg)*lanes + j];
    end
  end

  vec_mul_int #(
    .bit_width (bit_width),
    .lanes     (lanes),
    .prd_width (prd_width)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

`ifdef VEC_MUL_SEQ_PIPE_EN
  logic                        drain_reg, drain_next;
  logic                        pipe_vld_reg;
  logic [beat_w-1:0]           pipe_idx_reg;
  logic signed [prd_width-1:0] pipe_prd_reg [lanes];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drain_reg    <= 1'b0;
      pipe_vld_reg <= 1'b0;
      pipe_idx_reg <= '0;
      for (int j = 0; j < lanes; j++) pipe_prd_reg[j] <= '0;
    end else begin
      drain_reg    <= drain_next;
      pipe_vld_reg <= (state_reg == ST_RUN) && !drain_reg;
      pipe_idx_reg <= beat_reg;
      for (int j = 0; j < lanes; j++) pipe_prd_reg[j] <= mul_p[j];
    end
  end

  assign wr_en  = pipe_vld_reg;
  assign wr_idx = pipe_idx_reg;
  assign wr_prd = pipe_prd_reg;
`else
  assign wr_en  = (state_reg == ST_RUN);
  assign wr_idx = beat_reg;
  assign wr_prd = mul_p;
`endif

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    accept     = 1'b0;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_busy     = 1'b0;
    o_beat     = '0;
`ifdef VEC_MUL_SEQ_PIPE_EN
    drain_next = drain_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          beat_next  = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        o_beat = beat_reg;
`ifdef VEC_MUL_SEQ_PIPE_EN
        // One extra cycle lets the last beat leave the pipe stage.
        if (drain_reg) begin
          drain_next = 1'b0;
          state_next = ST_DONE;
        end else if (last_beat) begin
          drain_next = 1'b1;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
`else
        if (last_beat) begin
          beat_next  = '0;
          state_next = ST_DONE;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      for (int i = 0; i < length; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        for (int i = 0; i < length; i++) begin
          a_reg[i] <= i_vec_a[i];
          b_reg[i] <= i_vec_b[i];
        end
      end
    end
  end

  // Each buffer slot only listens to the beat that owns it.
  for (genvar gi = 0; gi < length; gi++) begin : g_slot
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        prd_reg[gi] <= '0;
      end else if (wr_en && (wr_idx == beat_w'(gi/lanes))) begin
        prd_reg[gi] <= wr_prd[gi%lanes];
      end
    end
  end

  assign o_prd = prd_reg;

endmodule

// File: tb/tb_vec_mul_seq.sv
// Randomized self-checking bench for vec_mul_seq against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_vec_mul_seq;
  localparam int BW    = 8;
  localparam int LEN   = 32;
  localparam int LANES = 8;
  localparam int PW    = 2*BW;
  localparam int BEATS = LEN/LANES;
  localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef VEC_MUL_SEQ_PIPE_EN
  localparam int LAT = BEATS + 2;
`else
  localparam int LAT = BEATS + 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [BW-1:0] vec_a [LEN];
  logic signed [BW-1:0] vec_b [LEN];
  logic                 o_valid;
  logic                 i_ready;
  logic signed [PW-1:0] prd [LEN];
  logic                 o_busy;
  logic [BTW-1:0]       o_beat;

  logic signed [BW-1:0] ta [LEN];
  logic signed [BW-1:0] tb [LEN];
  longint               exp_prd [LEN];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vec_mul_seq #(.bit_width(BW), .length(LEN), .lanes(LANES), .prd_width(PW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_vec_a (vec_a),
    .i_vec_b (vec_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_prd   (prd),
    .o_busy  (o_busy),
    .o_beat  (o_beat)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_prd(input string tag);
    for (int i = 0; i < LEN; i++)
      check($sformatf("%s prd[%0d]", tag, i), longint'(prd[i]), exp_prd[i]);
  endtask

  // One job from ta/tb; hold>0 keeps i_ready low that many cycles after o_valid.
  task automatic do_job(input string tag, input int hold, input bit flip);
    int cyc;
    for (int i = 0; i < LEN; i++) exp_prd[i] = longint'(ta[i]) * longint'(tb[i]);
    i_ready = (hold == 0);
    cyc = 0;
    while (!o_ready && cyc < 100) begin tick(); cyc++; end
    check({tag, " ready_in"}, longint'(o_ready), 1);
    vec_a = ta;
    vec_b = tb;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    if (flip) for (int i = 0; i < LEN; i++) vec_a[i] = ~ta[i];
    cyc = 1;
    while (!o_valid && cyc < 50) begin
      if (cyc <= BEATS) check($sformatf("%s beat@%0d", tag, cyc), longint'(o_beat), cyc - 1);
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, LAT);
    check({tag, " busy"}, longint'(o_busy), 1);
    check_prd(tag);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        for (int i = 0; i < LEN; i++) begin
          vec_a[i] = BW'($urandom);
          vec_b[i] = BW'($urandom);
        end
        i_valid = 1'b1;
        tick();
        check($sformatf("%s hold_valid@%0d", tag, k), longint'(o_valid), 1);
        check($sformatf("%s hold_ready@%0d", tag, k), longint'(o_ready), 0);
      end
      i_valid = 1'b0;
      check_prd({tag, " held"});
      i_ready = 1'b1;
    end
    tick();
    check({tag, " valid_fall"}, longint'(o_valid), 0);
    check({tag, " ready_back"}, longint'(o_ready), 1);
    check_prd({tag, " after"});
  endtask

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < LEN; i++) begin
      ta[i] = BW'(a);
      tb[i] = BW'(b);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < LEN; i++) begin
      ta[i] = BW'($urandom);
      tb[i] = BW'($urandom);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) begin vec_a[i] = '0; vec_b[i] = '0; end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst ready", longint'(o_ready), 1);
    check("rst valid", longint'(o_valid), 0);
    check("rst busy", longint'(o_busy), 0);
    check("rst beat", longint'(o_beat), 0);
    for (int i = 0; i < LEN; i++) exp_prd[i] = 0;
    check_prd("rst");

    // Ramp a[i]=i-16, b=3
    for (int i = 0; i < LEN; i++) begin ta[i] = BW'(i - 16); tb[i] = BW'(3); end
    do_job("basic", 0, 1'b0);
    check("basic p0", longint'(prd[0]), -48);
    check("basic p31", longint'(prd[LEN-1]), 45);

    fill_const(-128, -128); do_job("ext_nn", 0, 1'b0);
    fill_const(-128, 127);  do_job("ext_np", 0, 1'b0);
    fill_const(0, -1);      do_job("ext_zero", 0, 1'b0);

    fill_rand(); do_job("backpressure", 10, 1'b0);
    fill_rand(); do_job("flip", 0, 1'b1);

    // Abort during beat 2: nothing may surface.
    fill_rand();
    vec_a = ta;
    vec_b = tb;
    i_ready = 1'b1;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (o_beat != BTW'(2) && cyc < 20) begin tick(); cyc++; end
    check("abort reach_beat2", longint'(o_beat), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort valid", longint'(o_valid), 0);
    check("abort busy", longint'(o_busy), 0);
    check("abort beat", longint'(o_beat), 0);
    check("abort ready", longint'(o_ready), 1);
    for (int i = 0; i < LEN; i++) exp_prd[i] = 0;
    check_prd("abort");
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_valid) cyc++;
    end
    check("abort no_valid", cyc, 0);
    fill_rand(); do_job("post_abort", 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      fill_rand();
      do_job($sformatf("rand%0d", n), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d, expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
